// File: rtl/fifo_sync_wc.sv
// Single-clock FWFT FIFO with integer-ratio width conversion (upsize, downsize or pass-through).
// Define FIFO_SYNC_WC_LEVEL_EN to add the registered level_o and almost_full_o outputs.
module fifo_sync_wc #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned WR_W       = 128,
    parameter int unsigned RD_W       = 512,
    parameter int unsigned AF_THRESH  = 48
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            wr_req_i,
    input  logic [WR_W-1:0] wr_data_i,
    output logic            full_o,
    input  logic            rd_req_i,
    output logic [RD_W-1:0] rd_data_o,
    output logic            empty_o
`ifdef FIFO_SYNC_WC_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        almost_full_o
`endif
);

    localparam int unsigned MAX_W = (WR_W > RD_W) ? WR_W : RD_W;
    localparam int unsigned MIN_W = (WR_W > RD_W) ? RD_W : WR_W;
    localparam int unsigned RATIO = MAX_W / MIN_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    if (MAX_W % MIN_W != 0) begin : g_bad_ratio
        $fatal(1, "fifo_sync_wc: max(WR_W,RD_W) must be a multiple of min(WR_W,RD_W)");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_sync_wc: FIFO_DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_wc: AF_THRESH must lie in 1..DEPTH");
    end

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [MAX_W-1:0] mem [DEPTH];
    logic [MAX_W-1:0] push_data;
    logic [MAX_W-1:0] head;
    logic             core_full, core_empty;
    logic             wr_acc, rd_acc;
    logic             push, pop;

    assign core_empty = (wr_ptr_q == rd_ptr_q);
    assign core_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign empty_o    = core_empty;
    assign wr_acc     = wr_req_i & ~full_o;
    assign rd_acc     = rd_req_i & ~empty_o;

    if (WR_W < RD_W) begin : g_up
        localparam int unsigned SW = $clog2(RATIO);
        localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);

        logic [SW-1:0]          k_q;
        logic [MAX_W-WR_W-1:0]  acc_q;
        logic                   k_last;

        assign k_last    = (k_q == SLICE_LAST);
        // Earlier slices keep packing while the core is full; only the completing one waits.
        assign full_o    = core_full & k_last;
        assign push      = wr_acc & k_last;
        assign pop       = rd_acc;
        assign push_data = {wr_data_i, acc_q};
        assign rd_data_o = head;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                k_q <= '0;
            end else if (clr_i) begin
                k_q <= '0;
            end else if (wr_acc) begin
                k_q <= k_last ? '0 : k_q + SW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (wr_acc && !k_last) begin
                for (int i = 0; i < int'(RATIO) - 1; i++) begin
                    if (k_q == SW'(i)) acc_q[i*WR_W +: WR_W] <= wr_data_i;
                end
            end
        end
    end else if (WR_W > RD_W) begin : g_dn
        localparam int unsigned SW = $clog2(RATIO);
        localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);

        logic [SW-1:0] j_q;
        logic          j_last;

        assign j_last    = (j_q == SLICE_LAST);
        assign full_o    = core_full;
        assign push      = wr_acc;
        assign pop       = rd_acc & j_last;
        assign push_data = wr_data_i;
        assign rd_data_o = head[j_q*RD_W +: RD_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                j_q <= '0;
            end else if (clr_i) begin
                j_q <= '0;
            end else if (rd_acc) begin
                j_q <= j_last ? '0 : j_q + SW'(1);
            end
        end
    end else begin : g_eq
        assign full_o    = core_full;
        assign push      = wr_acc;
        assign pop       = rd_acc;
        assign push_data = wr_data_i;
        assign rd_data_o = head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage is deliberately not reset; stale contents are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (push && !clr_i) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

`ifdef FIFO_SYNC_WC_LEVEL_EN
    logic [AW:0] level_q, level_d;
    logic        almost_full_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + PTR_ONE;
        else if (pop && !push) level_d = level_q - PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else if (clr_i) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            almost_full_q <= (level_d >= (AW + 1)'(AF_THRESH));
        end
    end

    assign level_o       = level_q;
    assign almost_full_o = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_sync_wc.sv
// Directed bench for fifo_sync_wc: upsize, downsize and equal-width instances checked against
// queue-based models every cycle, plus hand-computed literal expectations.
module tb_fifo_sync_wc;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic         up_wr = 1'b0, up_rd = 1'b0, up_full, up_empty;
    logic [127:0] up_wd = '0;
    logic [511:0] up_rdata;
    logic         dn_wr = 1'b0, dn_rd = 1'b0, dn_full, dn_empty;
    logic [511:0] dn_wd = '0;
    logic [127:0] dn_rdata;
    logic         eq_wr = 1'b0, eq_rd = 1'b0, eq_full, eq_empty;
    logic [7:0]   eq_wd = '0;
    logic [7:0]   eq_rdata;
`ifdef FIFO_SYNC_WC_LEVEL_EN
    logic [2:0]   up_level, dn_level, eq_level;
    logic         up_af, dn_af, eq_af;
`endif

    fifo_sync_wc #(.FIFO_DEPTH(DEPTH), .WR_W(128), .RD_W(512), .AF_THRESH(AF)) u_up (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .wr_req_i(up_wr), .wr_data_i(up_wd), .full_o(up_full),
        .rd_req_i(up_rd), .rd_data_o(up_rdata), .empty_o(up_empty)
`ifdef FIFO_SYNC_WC_LEVEL_EN
        , .level_o(up_level), .almost_full_o(up_af)
`endif
    );

    fifo_sync_wc #(.FIFO_DEPTH(DEPTH), .WR_W(512), .RD_W(128), .AF_THRESH(AF)) u_dn (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .wr_req_i(dn_wr), .wr_data_i(dn_wd), .full_o(dn_full),
        .rd_req_i(dn_rd), .rd_data_o(dn_rdata), .empty_o(dn_empty)
`ifdef FIFO_SYNC_WC_LEVEL_EN
        , .level_o(dn_level), .almost_full_o(dn_af)
`endif
    );

    fifo_sync_wc #(.FIFO_DEPTH(DEPTH), .WR_W(8), .RD_W(8), .AF_THRESH(AF)) u_eq (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .wr_req_i(eq_wr), .wr_data_i(eq_wd), .full_o(eq_full),
        .rd_req_i(eq_rd), .rd_data_o(eq_rdata), .empty_o(eq_empty)
`ifdef FIFO_SYNC_WC_LEVEL_EN
        , .level_o(eq_level), .almost_full_o(eq_af)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: accepted narrow words (upsize), read-width slices (downsize), words (equal).
    logic [127:0] up_q[$];
    logic [127:0] dn_q[$];
    logic [7:0]   eq_q[$];

    function automatic int up_ent();
        return up_q.size() / 4;
    endfunction
    function automatic logic up_full_m();
        return (up_ent() == DEPTH) && (up_q.size() % 4 == 3);
    endfunction
    function automatic logic up_empty_m();
        return up_ent() == 0;
    endfunction
    function automatic int dn_ent();
        return (dn_q.size() + 3) / 4;
    endfunction
    function automatic logic dn_full_m();
        return dn_ent() == DEPTH;
    endfunction
    function automatic logic dn_empty_m();
        return dn_q.size() == 0;
    endfunction
    function automatic logic eq_full_m();
        return eq_q.size() == DEPTH;
    endfunction
    function automatic logic eq_empty_m();
        return eq_q.size() == 0;
    endfunction

    task automatic model_step();
        logic up_wa, up_ra, dn_wa, dn_ra, eq_wa, eq_ra;
        up_wa = up_wr && !up_full_m();
        up_ra = up_rd && !up_empty_m();
        dn_wa = dn_wr && !dn_full_m();
        dn_ra = dn_rd && !dn_empty_m();
        eq_wa = eq_wr && !eq_full_m();
        eq_ra = eq_rd && !eq_empty_m();
        if (up_ra) repeat (4) void'(up_q.pop_front());
        if (up_wa) up_q.push_back(up_wd);
        if (dn_ra) void'(dn_q.pop_front());
        if (dn_wa) for (int i = 0; i < 4; i++) dn_q.push_back(dn_wd[i*128 +: 128]);
        if (eq_ra) void'(eq_q.pop_front());
        if (eq_wa) eq_q.push_back(eq_wd);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            up_q.delete();
            dn_q.delete();
            eq_q.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("up_empty", up_empty, up_empty_m());
        check("up_full", up_full, up_full_m());
        if (!up_empty_m()) check("up_data", up_rdata, {up_q[3], up_q[2], up_q[1], up_q[0]});
        check("dn_empty", dn_empty, dn_empty_m());
        check("dn_full", dn_full, dn_full_m());
        if (!dn_empty_m()) check("dn_data", dn_rdata, dn_q[0]);
        check("eq_empty", eq_empty, eq_empty_m());
        check("eq_full", eq_full, eq_full_m());
        if (!eq_empty_m()) check("eq_data", eq_rdata, eq_q[0]);
`ifdef FIFO_SYNC_WC_LEVEL_EN
        check("up_level", up_level, up_ent());
        check("up_af", up_af, up_ent() >= AF);
        check("dn_level", dn_level, dn_ent());
        check("dn_af", dn_af, dn_ent() >= AF);
        check("eq_level", eq_level, eq_q.size());
        check("eq_af", eq_af, eq_q.size() >= AF);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] dn_exp [4];

    initial begin
        dn_exp[0] = 128'hA1;
        dn_exp[1] = 128'hB2;
        dn_exp[2] = 128'hC3;
        dn_exp[3] = 128'hD4;

        repeat (2) tick();
        check("rst_up_empty", up_empty, 1'b1);
        check("rst_up_full", up_full, 1'b0);
        check("rst_dn_empty", dn_empty, 1'b1);
        check("rst_eq_full", eq_full, 1'b0);
        rst_n = 1'b1;
        tick();

        // Upsize: four slices pack into one word, LSB first.
        up_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            up_wd = 128'(i);
            tick();
            if (i == 3) check("up_partial_empty", up_empty, 1'b1);
        end
        up_wr = 1'b0;
        check("up_pack_empty", up_empty, 1'b0);
        check("up_pack_data", up_rdata, {128'h4, 128'h3, 128'h2, 128'h1});
        up_rd = 1'b1;
        tick();
        up_rd = 1'b0;
        check("up_drain_empty", up_empty, 1'b1);

        // Downsize: one wide word splits into four reads, LSB slice first.
        dn_wr = 1'b1;
        dn_wd = {128'hD4, 128'hC3, 128'hB2, 128'hA1};
        tick();
        dn_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("dn_slice", dn_rdata, dn_exp[i]);
            dn_rd = 1'b1;
            tick();
            dn_rd = 1'b0;
        end
        check("dn_drain_empty", dn_empty, 1'b1);

        // Equal width: fill, blocked write on full with concurrent read, then traffic across wrap.
        eq_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eq_wd = 8'h10 + 8'(i);
            tick();
        end
        check("eq_fill_full", eq_full, 1'b1);
        eq_rd = 1'b1;
        eq_wd = 8'h99;
        tick();
        check("eq_full_after_rdwr", eq_full, 1'b0);
        check("eq_head_after_rdwr", eq_rdata, 8'h11);
        for (int i = 0; i < 10; i++) begin
            eq_wd = 8'h20 + 8'(i);
            tick();
        end
        eq_wr = 1'b0;
        check("eq_wrap_head", eq_rdata, 8'h27);
        repeat (3) tick();
        eq_rd = 1'b0;
        check("eq_drain_empty", eq_empty, 1'b1);

        // Upsize with core full and k=2: completing slice is blocked until a read frees an entry.
        up_wr = 1'b1;
        for (int i = 0; i < 18; i++) begin
            up_wd = 128'h100 + 128'(i);
            tick();
        end
        check("up_full_k2", up_full, 1'b0);
        up_wd = 128'h200;
        tick();
        check("up_full_k3", up_full, 1'b1);
        up_wd = 128'h201;
        tick();
        check("up_blocked", up_full, 1'b1);
        up_rd = 1'b1;
        tick();
        up_rd = 1'b0;
        check("up_full_after_read", up_full, 1'b0);
        check("up_head_after_pop", up_rdata, {128'h107, 128'h106, 128'h105, 128'h104});
        tick();
        up_wr = 1'b0;
        check("up_full_after_push", up_full, 1'b0);
`ifdef FIFO_SYNC_WC_LEVEL_EN
        check("up_level_4", up_level, 3'd4);
        check("up_af_set", up_af, 1'b1);
`endif
        up_rd = 1'b1;
        repeat (3) tick();
        check("up_last_entry", up_rdata, {128'h201, 128'h200, 128'h111, 128'h110});
        tick();
        up_rd = 1'b0;
        check("up_drain2_empty", up_empty, 1'b1);

        // Clear with 3 entries plus a partial word and same-cycle requests.
        up_wr = 1'b1;
        for (int i = 0; i < 14; i++) begin
            up_wd = 128'h300 + 128'(i);
            tick();
        end
        clr = 1'b1;
        up_rd = 1'b1;
        up_wd = 128'hBAD;
        tick();
        clr = 1'b0;
        up_rd = 1'b0;
        up_wr = 1'b0;
        check("clr_empty", up_empty, 1'b1);
        check("clr_full", up_full, 1'b0);
`ifdef FIFO_SYNC_WC_LEVEL_EN
        check("clr_level", up_level, 3'd0);
`endif
        up_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            up_wd = 128'h400 + 128'(i);
            tick();
        end
        up_wr = 1'b0;
        check("clr_fresh_data", up_rdata, {128'h404, 128'h403, 128'h402, 128'h401});
        up_rd = 1'b1;
        tick();
        up_rd = 1'b0;

        // Asynchronous reset mid-packing (2 entries, k=2).
        up_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            up_wd = 128'h500 + 128'(i);
            tick();
        end
        up_wr = 1'b0;
        check("pre_rst_empty", up_empty, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_empty", up_empty, 1'b1);
        check("rst_async_full", up_full, 1'b0);
`ifdef FIFO_SYNC_WC_LEVEL_EN
        check("rst_async_level", up_level, 3'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        up_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            up_wd = 128'h600 + 128'(i);
            tick();
        end
        up_wr = 1'b0;
        check("post_rst_data", up_rdata, {128'h604, 128'h603, 128'h602, 128'h601});
        up_rd = 1'b1;
        tick();
        up_rd = 1'b0;
        check("post_rst_empty", up_empty, 1'b1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
